s2p_rx: RTL

//  Deserialiser downstream of the column P2S stage. Samples the LSB-first serial ADC stream on

---
 rtl/s2p_rx.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/s2p_rx.sv
// s2p_rx: LSB-first serial-to-parallel word receiver with a show-ahead output FIFO and frame pulse.
// Optional saturating error counter enabled by defining RX_ERR_CNT_EN.
module s2p_rx #(
  parameter int BITS_ADC   = 12,
  parameter int NUM_COL    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_50M,
  input  logic                rst_n,
  input  logic                s_data,
  input  logic                data_valid,
  input  logic                rd_en,
  input  logic                ovf_clr,
  output logic [BITS_ADC-1:0] rd_data,
  output logic                empty,
  output logic                full,
  output logic                frame_done,
  output logic                overflow,
  output logic                abort
`ifdef RX_ERR_CNT_EN
  ,
  output logic [7:0]          err_cnt
`endif
);

  localparam int BC_W  = $clog2(BITS_ADC);
  localparam int IDX_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(BITS_ADC - 1);
  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(NUM_COL - 1);
  localparam logic [CNT_W-1:0] DEPTH    = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, RECV} state_t;

  state_t              state_reg;
  logic [BC_W-1:0]     bit_cnt_reg;
  logic [BITS_ADC-2:0] shreg_reg;
  logic [IDX_W-1:0]    word_idx_reg;
  logic [PTR_W-1:0]    wr_ptr_reg;
  logic [PTR_W-1:0]    rd_ptr_reg;
  logic [CNT_W-1:0]    count_reg;
  logic                frame_done_reg;
  logic                overflow_reg;
  logic                abort_reg;
  logic [BITS_ADC-1:0] mem [FIFO_DEPTH];

  logic                sample;
  logic                push_req;
  logic                pop;
  logic                push_ok;
  logic                ovf_evt;
  logic                abort_evt;
  logic [BITS_ADC-1:0] new_word;
  logic [BITS_ADC-2:0] shreg_next;

  assign sample     = !data_valid;
  assign push_req   = (state_reg == RECV) && sample && (bit_cnt_reg == LAST_BIT);
  assign new_word   = {s_data, shreg_reg};
  assign shreg_next = {s_data, shreg_reg[BITS_ADC-2:1]};
  assign pop        = rd_en && (count_reg != '0);
  // A full FIFO still accepts the word when the head leaves on the same edge.
  assign push_ok    = push_req && ((count_reg != DEPTH) || pop);
  assign ovf_evt    = push_req && (count_reg == DEPTH) && !pop;
  assign abort_evt  = (state_reg == RECV) && data_valid && (bit_cnt_reg != '0);

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shreg_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sample) begin
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= BC_W'(1);
            state_reg   <= RECV;
          end
        end
        RECV: begin
          if (sample) begin
            shreg_reg   <= shreg_next;
            bit_cnt_reg <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + BC_W'(1);
          end else begin
            bit_cnt_reg <= '0;
            state_reg   <= IDLE;
          end
        end
        default: begin
          bit_cnt_reg <= '0;
          state_reg   <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50M) begin
    if (push_ok) mem[wr_ptr_reg] <= new_word;
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push_ok && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (!push_ok && pop) count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Dropped words still advance the column index so frame alignment survives overflow.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      word_idx_reg   <= '0;
      frame_done_reg <= 1'b0;
      overflow_reg   <= 1'b0;
      abort_reg      <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      if (abort_evt) begin
        word_idx_reg <= '0;
      end else if (push_req) begin
        if (word_idx_reg == LAST_COL) begin
          word_idx_reg   <= '0;
          frame_done_reg <= 1'b1;
        end else begin
          word_idx_reg <= word_idx_reg + IDX_W'(1);
        end
      end
      if (ovf_evt)      overflow_reg <= 1'b1;
      else if (ovf_clr) overflow_reg <= 1'b0;
      if (abort_evt)    abort_reg <= 1'b1;
      else if (ovf_clr) abort_reg <= 1'b0;
    end
  end

`ifdef RX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_reg <= '0;
    end else if (ovf_evt || abort_evt) begin
      if (ovf_clr)                   err_cnt_reg <= 8'd1;
      else if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
    end else if (ovf_clr) begin
      err_cnt_reg <= '0;
    end
  end

  assign err_cnt = err_cnt_reg;
`endif

  assign rd_data    = (count_reg == '0) ? '0 : mem[rd_ptr_reg];
  assign empty      = (count_reg == '0);
  assign full       = (count_reg == DEPTH);
  assign frame_done = frame_done_reg;
  assign overflow   = overflow_reg;
  assign abort      = abort_reg;

endmodule
